beta_dcache: RTL

Parametrised direct-mapped, write-through, no-write-allocate data cache for the beta core, sitting between the datapath memory port (ALU-generated address, register-file write data) and backing memory. It is the next generation of the fixed-size core cache: line count and widths are parameters, and it adds a single-cycle flush plus saturating hit/miss counters. It stalls the core with `stall` while a fill or write-through is outstanding.

---
 rtl/beta_dcache.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/beta_dcache.sv
// beta_dcache: direct-mapped, write-through, no-write-allocate data cache.
// Each line holds a single word. Hits are answered combinationally in the request
// cycle. Misses fill from backing memory, and the returned word is bypassed to the core.
// Stores are written through to memory. A store updates the line only when it hits.
// The single-cycle flush clears every valid bit. The load hit and miss counters saturate.
module beta_dcache #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LINES  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memWriteData,
  input  logic              flush,
  input  logic [DATA_W-1:0] memReadData,
  input  logic              MemReadReady,
  input  logic              MemWriteDone,
  output logic [DATA_W-1:0] memData,
  output logic              stall,
  output logic              MemHit,
  output logic              MemReadDone,
  output logic              MemWriteReady,
  output logic [CNT_W-1:0]  hitCount,
  output logic [CNT_W-1:0]  missCount
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t            r_state;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_unused_byte_bits;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign w_idx = memAddr[2 +: IDX_W];
  assign w_tag = memAddr[ADDR_W-1 : 2+IDX_W];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // Byte offset within the word does not take part in lookup.
  assign w_unused_byte_bits = &{1'b0, memAddr[1:0]};

  assign hitCount  = r_hit_cnt;
  assign missCount = r_miss_cnt;

  // Core and memory handshake outputs, decoded from state, lookup result and strobes.
  always_comb begin
    memData       = {DATA_W{1'b0}};
    stall         = 1'b0;
    MemHit        = 1'b0;
    MemReadDone   = 1'b0;
    MemWriteReady = 1'b0;
    if (reset) begin
      memData       = {DATA_W{1'b0}};
      stall         = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            // The request is held and serviced next cycle, after the lines are invalidated.
            stall = MemRead | MemWrite;
          end else if (MemWrite) begin
            stall = 1'b1;
          end else if (MemRead) begin
            if (w_hit) begin
              MemHit  = 1'b1;
              memData = r_data[w_idx];
            end else begin
              stall = 1'b1;
            end
          end else begin
            stall = 1'b0;
          end
        end
        ST_FILL: begin
          stall = ~MemReadReady;
          if (MemReadReady) begin
            memData     = memReadData;
            MemReadDone = 1'b1;
          end else begin
            MemReadDone = 1'b0;
          end
        end
        ST_WRITE: begin
          MemWriteReady = 1'b1;
          stall         = ~MemWriteDone;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  // Controller state, line contents and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_valid    <= {LINES{1'b0}};
      r_hit_cnt  <= {CNT_W{1'b0}};
      r_miss_cnt <= {CNT_W{1'b0}};
      for (int i = 0; i < LINES; i++) begin
        r_tag[i]  <= {TAG_W{1'b0}};
        r_data[i] <= {DATA_W{1'b0}};
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            r_valid <= {LINES{1'b0}};
          end else if (MemWrite) begin
            r_state <= ST_WRITE;
          end else if (MemRead) begin
            if (w_hit) begin
              r_hit_cnt <= sat_inc(r_hit_cnt);
            end else begin
              r_miss_cnt <= sat_inc(r_miss_cnt);
              r_state    <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (MemReadReady) begin
            r_valid[w_idx] <= 1'b1;
            r_tag[w_idx]   <= w_tag;
            r_data[w_idx]  <= memReadData;
            r_state        <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (MemWriteDone) begin
            // No write-allocate: only a resident line picks up the store data.
            if (w_hit) begin
              r_data[w_idx] <= memWriteData;
            end
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
